systolic_drain: RTL and testbench

Output-side collector for the 8x8 systolic shift array. Array outputs leave skewed: for one result row, lane j arrives j cycles after lane 0. This block de-skews each row back into an aligned vector and buffers rows in a small FIFO. It presents them downstream on a valid/ready handshake and flags overflow when the FIFO is full.

---
 rtl/systolic_drain.sv | 160 ++++++++++++++++
 tb/tb_systolic_drain.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_drain.sv
// rtl/systolic_drain.sv - de-skews systolic array output rows and buffers them in a show-ahead FIFO
module systolic_drain #(
  parameter int LANES = 8,
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [LANES*WIDTH-1:0]     in_data,
  input  logic                       in_valid,
  output logic [LANES*WIDTH-1:0]     out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow,
  output logic [7:0]                 row_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int RW = LANES * WIDTH;

  localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  // ------------------------------------------------------------------
  // Row framing: in_valid travels alongside lane 0, so after LANES-1
  // stages it marks the cycle in which the last lane is present.
  // ------------------------------------------------------------------
  logic [LANES-2:0] vpipe_q;
  logic             row_done;

  // Shift in_valid down the row-completion pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      vpipe_q <= '0;
    end else begin
      vpipe_q[0] <= in_valid;
      for (int i = 1; i < LANES-1; i++) begin
        vpipe_q[i] <= vpipe_q[i-1];
      end
    end
  end

  assign row_done = vpipe_q[LANES-2];

  // ------------------------------------------------------------------
  // Deskew: lane j arrives j cycles after lane 0, so it is delayed by
  // the remaining LANES-1-j cycles. The last lane needs no delay and is
  // taken straight from the input in the completion cycle.
  // ------------------------------------------------------------------
  logic [RW-1:0] row_vec;

  for (genvar j = 0; j < LANES-1; j++) begin : g_lane
    localparam int D = LANES - 1 - j;
    logic [WIDTH-1:0] sr_q [D];

    // Per-lane delay line aligning this lane with the last lane.
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int k = 0; k < D; k++) begin
          sr_q[k] <= '0;
        end
      end else begin
        sr_q[0] <= in_data[j*WIDTH +: WIDTH];
        for (int k = 1; k < D; k++) begin
          sr_q[k] <= sr_q[k-1];
        end
      end
    end

    assign row_vec[j*WIDTH +: WIDTH] = sr_q[D-1];
  end

  assign row_vec[(LANES-1)*WIDTH +: WIDTH] = in_data[(LANES-1)*WIDTH +: WIDTH];

  // ------------------------------------------------------------------
  // Row FIFO. A pop in the same cycle as a write at full frees the slot
  // first, so the incoming row is kept; only an unrelieved full write
  // drops the row and latches overflow.
  // ------------------------------------------------------------------
  logic [RW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          overflow_q, overflow_d;
  logic [7:0]    row_count_q, row_count_d;

  logic          full;
  logic          pop;
  logic          push_ok;
  logic          drop;

  assign full    = (level_q == LVL_FULL);
  assign pop     = out_valid & out_ready;
  assign push_ok = row_done & (~full | pop);
  assign drop    = row_done & full & ~pop;

  // Next-state for pointers, occupancy, sticky overflow and the pop counter.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    overflow_d  = overflow_q;
    row_count_d = row_count_q;

    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d    = rd_ptr_q + PTR_ONE;
      row_count_d = row_count_q + 8'd1;
    end
    case ({push_ok, pop})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
    if (drop) begin
      overflow_d = 1'b1;
    end
  end

  // Register FIFO control state.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      overflow_q  <= 1'b0;
      row_count_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      overflow_q  <= overflow_d;
      row_count_q <= row_count_d;
    end
  end

  // Row storage; cleared on reset so the head reads as zero afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push_ok) begin
      mem_q[wr_ptr_q] <= row_vec;
    end
  end

  // Show-ahead head: the entry at rd_ptr is stable until it is popped,
  // since a write can only land on it in the very cycle it is popped.
  assign out_data  = mem_q[rd_ptr_q];
  assign out_valid = (level_q != '0);
  assign level     = level_q;
  assign overflow  = overflow_q;
  assign row_count = row_count_q;

endmodule

// File: tb/tb_systolic_drain.sv
// tb/tb_systolic_drain.sv - directed self-checking bench for systolic_drain
module tb_systolic_drain;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] level;
  logic       overflow;
  logic [7:0] row_count;

  int errors = 0;
  int checks = 0;

  systolic_drain #(.LANES(8), .WIDTH(1), .DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .level     (level),
    .overflow  (overflow),
    .row_count (row_count)
  );

  always #5 clk = ~clk;

  // row schedule: row r starts (lane 0) at relative cycle rstart[r]
  int         nrows;
  int         rstart [0:299];
  logic [7:0] rv     [0:299];
  logic       rdy_s  [0:399];
  int         rst_at;

  // per-cycle observations
  logic       ov_r [0:399];
  logic [2:0] lv_r [0:399];
  logic       of_r [0:399];
  logic [7:0] rc_r [0:399];

  logic [7:0] cap [$];

  always @(negedge clk) begin
    if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1)
      cap.push_back(out_data);
  end

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = 8'h00;
    out_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    cap.delete();
    nrows = 0;
    rst_at = -1;
    for (int k = 0; k < 400; k++) rdy_s[k] = 1'b0;
  endtask

  task automatic add_row(input int s, input logic [7:0] v);
    rstart[nrows] = s;
    rv[nrows] = v;
    nrows++;
  endtask

  task automatic play(input int n);
    for (int k = 0; k < n; k++) begin
      in_valid = 1'b0;
      in_data = 8'h00;
      for (int r = 0; r < nrows; r++) begin
        if (rstart[r] == k) in_valid = 1'b1;
        for (int j = 0; j < 8; j++)
          if (rstart[r] + j == k) in_data[j] = rv[r][j];
      end
      out_ready = rdy_s[k];
      rst = (k == rst_at);
      ov_r[k] = out_valid;
      lv_r[k] = level;
      of_r[k] = overflow;
      rc_r[k] = row_count;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_data = 8'h00;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL rst_level got=%0d exp=0", level); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_overflow got=%b exp=0", overflow); end
    checks++; if (row_count !== 8'd0) begin errors++; $display("FAIL rst_row_count got=%0d exp=0", row_count); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL rst_out_data got=%h exp=00", out_data); end
  endtask

  task automatic test_single_row();
    int cnt;
    do_reset();
    for (int k = 0; k < 400; k++) rdy_s[k] = 1'b1;
    add_row(10, 8'hAA);
    play(30);
    cnt = 0;
    for (int k = 0; k < 30; k++) if (ov_r[k] === 1'b1) cnt++;
    checks++; if (ov_r[17] !== 1'b0) begin errors++; $display("FAIL t1_valid17 got=%b exp=0", ov_r[17]); end
    checks++; if (ov_r[18] !== 1'b1) begin errors++; $display("FAIL t1_valid18 got=%b exp=1", ov_r[18]); end
    checks++; if (cnt != 1) begin errors++; $display("FAIL t1_valid_cycles got=%0d exp=1", cnt); end
    checks++; if (cap.size() != 1) begin errors++; $display("FAIL t1_rows got=%0d exp=1", cap.size()); end
    else begin
      checks++; if (cap[0] !== 8'hAA) begin errors++; $display("FAIL t1_data got=%h exp=aa", cap[0]); end
    end
    checks++; if (rc_r[19] !== 8'd1) begin errors++; $display("FAIL t1_row_count got=%0d exp=1", rc_r[19]); end
    checks++; if (lv_r[19] !== 3'd0) begin errors++; $display("FAIL t1_level got=%0d exp=0", lv_r[19]); end
  endtask

  task automatic test_back_to_back();
    int cnt;
    logic [7:0] exp_v [0:3];
    exp_v[0] = 8'hFF; exp_v[1] = 8'h00; exp_v[2] = 8'h5A; exp_v[3] = 8'hC3;
    do_reset();
    for (int k = 0; k < 400; k++) rdy_s[k] = 1'b1;
    for (int i = 0; i < 4; i++) add_row(10 + i, exp_v[i]);
    play(30);
    cnt = 0;
    for (int k = 0; k < 30; k++) if (ov_r[k] === 1'b1) cnt++;
    checks++; if (ov_r[17] !== 1'b0 || ov_r[22] !== 1'b0) begin errors++; $display("FAIL t2_valid_edges got=%b%b exp=00", ov_r[17], ov_r[22]); end
    checks++; if (cnt != 4) begin errors++; $display("FAIL t2_valid_cycles got=%0d exp=4", cnt); end
    for (int k = 18; k <= 21; k++) begin
      checks++; if (ov_r[k] !== 1'b1) begin errors++; $display("FAIL t2_valid_c%0d got=%b exp=1", k, ov_r[k]); end
    end
    checks++; if (cap.size() != 4) begin errors++; $display("FAIL t2_rows got=%0d exp=4", cap.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        checks++; if (cap[i] !== exp_v[i]) begin errors++; $display("FAIL t2_data%0d got=%h exp=%h", i, cap[i], exp_v[i]); end
      end
    end
    checks++; if (of_r[29] !== 1'b0) begin errors++; $display("FAIL t2_overflow got=%b exp=0", of_r[29]); end
    checks++; if (rc_r[29] !== 8'd4) begin errors++; $display("FAIL t2_row_count got=%0d exp=4", rc_r[29]); end
  endtask

  task automatic test_full_drop();
    logic [7:0] exp_v [0:3];
    exp_v[0] = 8'h11; exp_v[1] = 8'h22; exp_v[2] = 8'h33; exp_v[3] = 8'h44;
    do_reset();
    for (int k = 30; k < 400; k++) rdy_s[k] = 1'b1;
    for (int i = 0; i < 4; i++) add_row(10 + i, exp_v[i]);
    add_row(14, 8'h55);
    play(45);
    checks++; if (of_r[21] !== 1'b0) begin errors++; $display("FAIL t3_overflow_early got=%b exp=0", of_r[21]); end
    checks++; if (lv_r[29] !== 3'd4) begin errors++; $display("FAIL t3_level_full got=%0d exp=4", lv_r[29]); end
    checks++; if (of_r[29] !== 1'b1) begin errors++; $display("FAIL t3_overflow got=%b exp=1", of_r[29]); end
    checks++; if (cap.size() != 4) begin errors++; $display("FAIL t3_rows got=%0d exp=4", cap.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        checks++; if (cap[i] !== exp_v[i]) begin errors++; $display("FAIL t3_data%0d got=%h exp=%h", i, cap[i], exp_v[i]); end
      end
    end
    checks++; if (lv_r[40] !== 3'd0) begin errors++; $display("FAIL t3_level_drained got=%0d exp=0", lv_r[40]); end
    checks++; if (of_r[44] !== 1'b1) begin errors++; $display("FAIL t3_overflow_sticky got=%b exp=1", of_r[44]); end
  endtask

  task automatic test_push_pop_full();
    logic [7:0] exp_v [0:4];
    exp_v[0] = 8'hA1; exp_v[1] = 8'hA2; exp_v[2] = 8'hA3; exp_v[3] = 8'hA4; exp_v[4] = 8'hA5;
    do_reset();
    rdy_s[27] = 1'b1;
    for (int k = 35; k < 400; k++) rdy_s[k] = 1'b1;
    for (int i = 0; i < 4; i++) add_row(10 + i, exp_v[i]);
    add_row(20, exp_v[4]);
    play(50);
    checks++; if (lv_r[27] !== 3'd4) begin errors++; $display("FAIL t4_level_before got=%0d exp=4", lv_r[27]); end
    checks++; if (lv_r[28] !== 3'd4) begin errors++; $display("FAIL t4_level_after got=%0d exp=4", lv_r[28]); end
    checks++; if (of_r[28] !== 1'b0) begin errors++; $display("FAIL t4_overflow got=%b exp=0", of_r[28]); end
    checks++; if (cap.size() != 5) begin errors++; $display("FAIL t4_rows got=%0d exp=5", cap.size()); end
    else begin
      for (int i = 0; i < 5; i++) begin
        checks++; if (cap[i] !== exp_v[i]) begin errors++; $display("FAIL t4_data%0d got=%h exp=%h", i, cap[i], exp_v[i]); end
      end
    end
    checks++; if (of_r[49] !== 1'b0) begin errors++; $display("FAIL t4_overflow_end got=%b exp=0", of_r[49]); end
  endtask

  task automatic test_reset_mid_row();
    int late;
    do_reset();
    for (int k = 0; k < 400; k++) rdy_s[k] = 1'b1;
    add_row(2, 8'h3C);
    add_row(10, 8'hFF);
    rst_at = 13;
    play(30);
    late = 0;
    for (int k = 14; k < 30; k++) if (ov_r[k] === 1'b1) late++;
    checks++; if (rc_r[13] !== 8'd1) begin errors++; $display("FAIL t5_row_count_pre got=%0d exp=1", rc_r[13]); end
    checks++; if (ov_r[14] !== 1'b0) begin errors++; $display("FAIL t5_valid14 got=%b exp=0", ov_r[14]); end
    checks++; if (lv_r[14] !== 3'd0) begin errors++; $display("FAIL t5_level14 got=%0d exp=0", lv_r[14]); end
    checks++; if (of_r[14] !== 1'b0) begin errors++; $display("FAIL t5_overflow14 got=%b exp=0", of_r[14]); end
    checks++; if (rc_r[14] !== 8'd0) begin errors++; $display("FAIL t5_row_count14 got=%0d exp=0", rc_r[14]); end
    checks++; if (late != 0) begin errors++; $display("FAIL t5_no_output got=%0d exp=0", late); end
    checks++; if (cap.size() != 1) begin errors++; $display("FAIL t5_rows got=%0d exp=1", cap.size()); end
  endtask

  task automatic test_counter_wrap();
    do_reset();
    for (int k = 0; k < 400; k++) rdy_s[k] = 1'b1;
    for (int r = 0; r < 257; r++) add_row(10 + r, 8'(r * 37 + 5));
    play(285);
    checks++; if (rc_r[284] !== 8'd1) begin errors++; $display("FAIL t6_row_count got=%0d exp=1", rc_r[284]); end
    checks++; if (of_r[284] !== 1'b0) begin errors++; $display("FAIL t6_overflow got=%b exp=0", of_r[284]); end
    checks++; if (lv_r[284] !== 3'd0) begin errors++; $display("FAIL t6_level got=%0d exp=0", lv_r[284]); end
    checks++; if (cap.size() != 257) begin errors++; $display("FAIL t6_rows got=%0d exp=257", cap.size()); end
    else begin
      checks++; if (cap[0] !== 8'd5) begin errors++; $display("FAIL t6_data0 got=%h exp=05", cap[0]); end
      checks++; if (cap[100] !== 8'd121) begin errors++; $display("FAIL t6_data100 got=%0d exp=121", cap[100]); end
      checks++; if (cap[256] !== 8'd5) begin errors++; $display("FAIL t6_data256 got=%h exp=05", cap[256]); end
    end
  endtask

  initial begin
    test_reset();
    test_single_row();
    test_back_to_back();
    test_full_drop();
    test_push_pop_full();
    test_reset_mid_row();
    test_counter_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
